// File: rtl/onoff_link_tx.sv
// On/off flow-controlled NoC link transmitter: staging FIFO feeding a registered write strobe.
// Accept-to-out_valid is two edges; in_ready drops while the FIFO is full; launches only while on_q is set.
`timescale 1ns/1ps

package params_noc;
  typedef struct packed {
    logic [1:0]  flit_type;
    logic [5:0]  dest;
    logic [23:0] payload;
  } flit_Data_noVC;
endpackage

module onoff_link_tx
  import params_noc::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  flit_Data_noVC    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             on_off_i,
  output flit_Data_noVC    out_data,
  output logic             out_valid,
  output logic             stalled,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stats_clr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             on_q, on_d;
  flit_Data_noVC    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  flit_Data_noVC    out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] sent_cnt_q, sent_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             push;
  logic             pop;

  assign in_ready = (occ_q != FULL_OCC);
  assign push     = in_valid & in_ready;
  // Launch looks only at pre-edge occupancy, so a flit written this edge waits one cycle (no bypass).
  assign pop      = on_q & (occ_q != '0);

  always_comb begin
    on_d        = on_off_i;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    out_data_d  = out_data_q;
    out_valid_d = pop;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      out_data_d = mem_q[rd_ptr_q];
    end
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (occ_d != '0) begin
          state_d = on_d ? SEND : HOLD;
        end
      end
      SEND: begin
        if (occ_d == '0) begin
          state_d = IDLE;
        end else if (!on_d) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (on_d) begin
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sent_cnt_d  = sent_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (stats_clr) begin
      sent_cnt_d  = '0;
      stall_cnt_d = '0;
    end else begin
      if (pop) begin
        sent_cnt_d = sent_cnt_q + CNT_W'(1);
      end
      if ((state_q == HOLD) && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      on_q        <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sent_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      on_q        <= on_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sent_cnt_q  <= sent_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign stalled   = (state_q == HOLD);
  assign sent_cnt  = sent_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_onoff_link_tx.sv
// Scoreboarded bench for onoff_link_tx: a default instance (depth 4) and a depth-3 / 4-bit-counter instance.
`timescale 1ns/1ps

module tb_onoff_link_tx;
  import params_noc::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic          a_rst_n, a_in_valid, a_in_ready, a_on, a_out_valid, a_stalled, a_clr;
  flit_Data_noVC a_in_data, a_out_data;
  logic [15:0]   a_sent, a_stall;

  logic          b_rst_n, b_in_valid, b_in_ready, b_on, b_out_valid, b_stalled, b_clr;
  flit_Data_noVC b_in_data, b_out_data;
  logic [3:0]    b_sent, b_stall;

  flit_Data_noVC sb_a[$];
  flit_Data_noVC sb_b[$];
  int a_seq = 0;
  int b_seq = 0;
  int occ_m = 0;
  logic onq_m = 1'b1;

  onoff_link_tx #(.FIFO_DEPTH(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(a_rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .on_off_i(a_on), .out_data(a_out_data), .out_valid(a_out_valid),
    .stalled(a_stalled), .sent_cnt(a_sent), .stall_cnt(a_stall), .stats_clr(a_clr)
  );

  onoff_link_tx #(.FIFO_DEPTH(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .on_off_i(b_on), .out_data(b_out_data), .out_valid(b_out_valid),
    .stalled(b_stalled), .sent_cnt(b_sent), .stall_cnt(b_stall), .stats_clr(b_clr)
  );

  function automatic flit_Data_noVC mk_flit(input logic [7:0] tag, input int unsigned n);
    return flit_Data_noVC'({tag, n[23:0]});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: every write strobe must carry the oldest accepted, not-yet-seen flit.
  always @(negedge clk) begin
    if (a_rst_n && a_out_valid) begin
      vectors++;
      if (sb_a.size() == 0) begin
        miscompares++;
        $display("FAIL a_flit: unexpected flit %h, none outstanding (t=%0t)", a_out_data, $time);
      end else begin
        flit_Data_noVC e;
        e = sb_a.pop_front();
        if (a_out_data !== e) begin
          miscompares++;
          $display("FAIL a_flit: got %h, expected %h (t=%0t)", a_out_data, e, $time);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b_rst_n && b_out_valid) begin
      vectors++;
      if (sb_b.size() == 0) begin
        miscompares++;
        $display("FAIL b_flit: unexpected flit %h, none outstanding (t=%0t)", b_out_data, $time);
      end else begin
        flit_Data_noVC e;
        e = sb_b.pop_front();
        if (b_out_data !== e) begin
          miscompares++;
          $display("FAIL b_flit: got %h, expected %h (t=%0t)", b_out_data, e, $time);
        end
      end
    end
  end

  task automatic step_a(input logic vld, input logic on);
    logic acc;
    a_in_valid = vld;
    a_on       = on;
    a_in_data  = mk_flit(8'hA5, a_seq);
    @(negedge clk);
    acc = a_in_valid & a_in_ready;
    if (acc) sb_a.push_back(a_in_data);
    @(posedge clk);
    #1;
    if (acc) a_seq++;
  endtask

  // Depth-3 instance also runs an occupancy / on-register model to check in_ready and launch timing.
  task automatic step_b(input logic vld, input logic on);
    logic acc;
    logic launch_m;
    b_in_valid = vld;
    b_on       = on;
    b_in_data  = mk_flit(8'hB7, b_seq);
    @(negedge clk);
    chk("b_in_ready", 32'(b_in_ready), 32'(occ_m != 3));
    acc = b_in_valid & b_in_ready;
    launch_m = onq_m && (occ_m != 0);
    if (acc) sb_b.push_back(b_in_data);
    @(posedge clk);
    #1;
    occ_m = occ_m + int'(acc) - int'(launch_m);
    onq_m = on;
    chk("b_launch", 32'(b_out_valid), 32'(launch_m));
    if (acc) b_seq++;
  endtask

  task automatic reset_a();
    a_rst_n = 1'b0; a_in_valid = 1'b0; a_on = 1'b1; a_clr = 1'b0;
    sb_a.delete();
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;
  endtask

  task automatic reset_b();
    b_rst_n = 1'b0; b_in_valid = 1'b0; b_on = 1'b1; b_clr = 1'b0;
    sb_b.delete();
    occ_m = 0;
    onq_m = 1'b1;
    @(posedge clk);
    #1;
    b_rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    int s0;
    int pulses;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_in_valid = 1'b0; b_in_valid = 1'b0; a_on = 1'b1; b_on = 1'b1;
    a_clr = 1'b0; b_clr = 1'b0; a_in_data = '0; b_in_data = '0;

    // Reset state
    reset_a();
    chk("a_rst_out_valid", 32'(a_out_valid), 0);
    chk("a_rst_in_ready", 32'(a_in_ready), 1);
    chk("a_rst_stalled", 32'(a_stalled), 0);
    chk("a_rst_out_data", 32'(a_out_data), 0);
    chk("a_rst_sent", 32'(a_sent), 0);
    chk("a_rst_stall", 32'(a_stall), 0);

    // Stream: ten back-to-back flits, strobes on the 2nd..11th edges
    for (int i = 0; i < 12; i++) begin
      step_a(i < 10, 1'b1);
      chk("stream_out_valid", 32'(a_out_valid), 32'(i >= 1 && i <= 10));
    end
    chk("stream_sent", 32'(a_sent), 10);

    // Off/on: off sampled at edge 5, on sampled at edge 10
    reset_a();
    s0 = a_seq;
    pulses = 0;
    for (int c = 1; c <= 25; c++) begin
      step_a((a_seq - s0) < 12, !(c >= 5 && c <= 9));
      if (c >= 6 && c <= 10) pulses += int'(a_out_valid);
      case (c)
        4:  chk("offon_sent3", 32'(a_sent), 3);
        5: begin
          chk("offon_last_pulse", 32'(a_out_valid), 1);
          chk("offon_stalled", 32'(a_stalled), 1);
        end
        8:  chk("offon_full", 32'(a_in_ready), 0);
        9:  chk("offon_stall4", 32'(a_stall), 4);
        10: begin
          chk("offon_no_pulses", 32'(pulses), 0);
          chk("offon_stall5", 32'(a_stall), 5);
          chk("offon_unstalled", 32'(a_stalled), 0);
          chk("offon_still_full", 32'(a_in_ready), 0);
        end
        11: begin
          chk("offon_resume", 32'(a_out_valid), 1);
          chk("offon_ready_back", 32'(a_in_ready), 1);
        end
        default: ;
      endcase
    end
    chk("offon_sent12", 32'(a_sent), 12);
    chk("offon_stall_final", 32'(a_stall), 5);
    chk("offon_sb_empty", 32'(sb_a.size()), 0);

    // Simultaneous push/pop with two flits resident
    reset_a();
    step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b1);
    chk("simul_prefill_vld", 32'(a_out_valid), 0);
    for (int i = 0; i < 8; i++) begin
      step_a(1'b1, 1'b1);
      chk("simul_in_ready", 32'(a_in_ready), 1);
      chk("simul_out_valid", 32'(a_out_valid), 1);
    end
    step_a(1'b0, 1'b1);
    chk("simul_drain1", 32'(a_out_valid), 1);
    step_a(1'b0, 1'b1);
    chk("simul_drain2", 32'(a_out_valid), 1);
    step_a(1'b0, 1'b1);
    chk("simul_drained", 32'(a_out_valid), 0);
    chk("simul_sent", 32'(a_sent), 10);
    chk("simul_stall", 32'(a_stall), 1);

    // Reset mid-stream with three flits queued and a strobe in flight
    reset_a();
    for (int i = 0; i < 3; i++) step_a(1'b1, 1'b0);
    step_a(1'b1, 1'b1);
    step_a(1'b0, 1'b1);
    chk("midrst_pre_vld", 32'(a_out_valid), 1);
    @(negedge clk);
    #1;
    a_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(a_out_valid), 0);
    chk("midrst_in_ready", 32'(a_in_ready), 1);
    chk("midrst_sent", 32'(a_sent), 0);
    sb_a.delete();
    @(posedge clk);
    #1;
    a_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step_a(1'b0, 1'b1);
      chk("midrst_silent", 32'(a_out_valid), 0);
    end

    // Depth-3 wrap with random valid and on/off
    reset_b();
    chk("b_rst_in_ready", 32'(b_in_ready), 1);
    chk("b_rst_out_valid", 32'(b_out_valid), 0);
    chk("b_rst_counts", 32'({b_sent, b_stall}), 0);
    s0 = b_seq;
    for (int g = 0; g < 300 && (b_seq - s0) < 20; g++) begin
      step_b(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end
    chk("wrap_accepted", 32'(b_seq - s0), 20);
    for (int i = 0; i < 10; i++) step_b(1'b0, 1'b1);
    chk("wrap_sb_empty", 32'(sb_b.size()), 0);
    chk("wrap_sent_mod16", 32'(b_sent), 4);

    // Saturation and clear
    step_b(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step_b(1'b0, 1'b0);
    chk("sat_stalled", 32'(b_stalled), 1);
    chk("sat_stall15", 32'(b_stall), 15);
    b_clr = 1'b1;
    step_b(1'b0, 1'b0);
    b_clr = 1'b0;
    chk("clr_stall", 32'(b_stall), 0);
    chk("clr_sent", 32'(b_sent), 0);
    step_b(1'b0, 1'b0);
    chk("clr_restart", 32'(b_stall), 1);
    for (int i = 0; i < 3; i++) step_b(1'b0, 1'b1);
    chk("clr_sent_after", 32'(b_sent), 1);
    chk("clr_stall_after", 32'(b_stall), 2);
    chk("clr_sb_empty", 32'(sb_b.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/onoff_link_tx.md
# onoff_link_tx

Upstream transmitter for one NoC link that uses on/off flow control. It accepts flits from the local router output stage through a valid/ready handshake and holds them in a small staging FIFO. It launches flits onto the link only while the downstream input buffer's on/off signal permits. Its outputs drive the downstream circular buffer's write strobe and data, and its `on_off_i` input is fed directly by that buffer's on/off output.

## Interface
- `FIFO_DEPTH`, default 4: staging FIFO entries, legal range ≥2, need not be a power of two.
- `CNT_W`, default 16: width of the statistics counters.

- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  flit_Data_noVC  flit from the local source, typed per params_noc.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  FIFO can accept a flit; a transfer occurs on an edge where `in_valid & in_ready`.
- `on_off_i`  in  1  downstream buffer permission; 1 = accepting, 0 = stop.
- `out_data`  out  flit_Data_noVC  registered flit to the downstream buffer `input_Data`.
- `out_valid`  out  1  registered write strobe to the downstream `write_i`; one cycle per flit.
- `stalled`  out  1  high while in state HOLD.
- `sent_cnt`  out  CNT_W  flits launched; wraps modulo 2^CNT_W.
- `stall_cnt`  out  CNT_W  cycles spent in HOLD; saturates at all-ones.
- `stats_clr`  in  1  synchronous clear of both counters.

## Operation
- **On/off register.** `on_q` registers `on_off_i` every edge and resets to 1, matching the downstream buffer's reset value.
- **Staging FIFO.** The FIFO holds FIFO_DEPTH flits. Read and write pointers wrap from FIFO_DEPTH-1 to 0. An occupancy counter is ceil(log2(FIFO_DEPTH+1)) bits wide.
  - `in_ready = (occupancy != FIFO_DEPTH)`, combinational from registered state.
- **Launch.** A launch occurs at an edge when `on_q==1` and occupancy is non-zero before that edge. On a launch:
  - the head entry is popped;
  - `out_data` takes the head entry and `out_valid` goes to 1 for the following cycle;
  - on all other edges `out_valid` goes to 0 and `out_data` holds its value.
- **Simultaneous push and pop.** These are allowed on the same edge and leave occupancy unchanged. An empty FIFO never launches on the edge that fills it, so there is no bypass.
- **FSM.** Next state is evaluated each edge from next-state occupancy and the new `on_q`:
  - IDLE: occupancy 0. Go to SEND if non-empty and `on_q`; go to HOLD if non-empty and not `on_q`.
  - SEND: launching. Go to IDLE when empty; go to HOLD when `on_q` falls.
  - HOLD: non-empty with `on_q==0`. Go to SEND when `on_q` rises. HOLD never goes directly to IDLE.
  - Launch is gated by `on_q` and occupancy, not by state encoding; `stalled` is `state==HOLD`.
- **Counters.**
  - `sent_cnt` increments on every launch.
  - `stall_cnt` increments on each edge where the current state is HOLD, saturating at all-ones.
  - `stats_clr` forces both to 0 on that edge, overriding any increment.
- **Reset values.** All outputs reset to 0 except `in_ready`, which is 1 when the FIFO is empty. `out_data` resets to all-zero. The state resets to IDLE, `on_q` to 1, and the pointers and occupancy to 0.
- **Reset mid-operation.** Reset discards FIFO contents and any in-flight `out_valid` immediately, asynchronously.

## Timing
- **Input-to-link latency.** A flit accepted at edge k into an empty FIFO produces `out_valid` in the cycle after edge k+1, provided `on_q==1` at edge k+1.
- **Throughput.** One flit per cycle while `on_q` stays 1 and input is continuous.
- **Off response.** If `on_off_i` is first sampled 0 at edge k, a launch can still occur at edge k. No launch occurs at edge k+1 or later until `on_q` returns to 1. At most one `out_valid` pulse is issued after the off edge, and the downstream threshold covers this.
- **On response.** If `on_off_i` is first sampled 1 at edge k, the first launch is at edge k+1.
- **Back-pressure.** `in_ready` falls in the cycle after the edge that makes occupancy FIFO_DEPTH. It rises in the cycle after the first pop that leaves the FIFO non-full without a simultaneous push.

## Test plan
- **Stream.** Reset, hold `on_off_i=1`, push 10 flits back-to-back. Expect `out_valid` on 10 consecutive cycles starting 2 cycles after the first accept, flits in order, and `sent_cnt=10`.
- **Off/on.** Stream with `on_off_i` falling when 3 flits have launched. Expect exactly 1 further pulse, `stalled=1` after 2 cycles, and `in_ready=0` once 4 flits are queued. Raise `on_off_i` after 5 HOLD cycles: expect `stall_cnt=5`, launches resuming 2 edges after the raise, and no flit lost or duplicated.
- **Wrap.** Use FIFO_DEPTH=3 and 20 flits with random `in_valid` and random `on_off_i`. Expect in-order delivery, pointers wrapping at 2→0, and `in_ready` never high while occupancy is 3.
- **Simultaneous push/pop.** Keep occupancy at 2 with a push and launch every cycle for 8 cycles. Expect occupancy to stay at 2 and `in_ready=1` throughout.
- **Counter clear and saturation.** Use CNT_W=4 and hold in HOLD for 20 cycles. Expect `stall_cnt` to saturate at 15. Pulse `stats_clr`: expect both counters to read 0 next cycle.
- **Reset mid-stream.** Assert `rst_n=0` with 3 flits queued and `out_valid=1`. Expect `out_valid=0` and `in_ready=1` asynchronously, and no flits emitted after release.
